// File: rtl/vision_pkg.sv
// Shared vision-datapath types: DMA command encodings and requester ids.
package vision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_DONE = 2'b11
  } dma_st_e;

  typedef enum logic {
    REQ_CAM = 1'b0,
    REQ_NN  = 1'b1
  } req_id_e;

  // Opposite requester; used for the round-robin tie break.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_CAM) ? REQ_NN : REQ_CAM;
  endfunction

endpackage

// File: rtl/pic_rr_arb2.sv
// Combinational 2-way round-robin pick between camera and accelerator requests.
module pic_rr_arb2
  import vision_pkg::*;
(
  input  logic    cam_req,
  input  logic    nn_req,
  input  req_id_e last_gnt,
  output logic    gnt_vld,
  output req_id_e gnt_id
);

  always_comb begin
    gnt_vld = cam_req | nn_req;
    gnt_id  = REQ_CAM;
    if (cam_req && nn_req) gnt_id = other_req(last_gnt);
    else if (nn_req)       gnt_id = REQ_NN;
  end

endmodule

// File: rtl/pic_dma_ctrl.sv
// Picture-buffer DMA sequencer: arbitrates cam/nn frame transfers and counts beats.
// Optional two-bank ping-pong buffering enabled by defining PIC_DMA_CTRL_PINGPONG_EN.
module pic_dma_ctrl
  import vision_pkg::*;
#(
  parameter int FRAME_WORDS = 1024,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cam_req,
  input  logic             nn_req,
  input  logic             abort,
  output logic             cam_gnt,
  output logic             nn_gnt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] beat,
  output logic             done,
  output logic             aborted,
  output logic             bank
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_WORDS - 1);

  dma_st_e st_q;
  req_id_e last_gnt;
  logic    frame_valid;
  logic    gnt_vld;
  req_id_e gnt_id;
  logic    in_xfer, xfer_end, cam_fin;

  // Reader may not start until a complete camera frame exists.
  pic_rr_arb2 u_arb (
    .cam_req  (cam_req),
    .nn_req   (nn_req & frame_valid),
    .last_gnt (last_gnt),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  assign in_xfer  = (st_q == ST_WR) || (st_q == ST_RD);
  assign xfer_end = in_xfer && (abort || (beat == LAST));
  assign cam_fin  = (st_q == ST_WR) && !abort && (beat == LAST);
  assign state    = st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      last_gnt    <= REQ_NN;
      frame_valid <= 1'b0;
      cam_gnt     <= 1'b0;
      nn_gnt      <= 1'b0;
      beat        <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            last_gnt <= gnt_id;
            beat     <= '0;
            if (gnt_id == REQ_CAM) begin
              st_q    <= ST_WR;
              cam_gnt <= 1'b1;
            end else begin
              st_q   <= ST_RD;
              nn_gnt <= 1'b1;
            end
          end
        end
        ST_WR, ST_RD: begin
          if (xfer_end) begin
            st_q    <= ST_DONE;
            done    <= 1'b1;
            aborted <= abort;
            cam_gnt <= 1'b0;
            nn_gnt  <= 1'b0;
            beat    <= '0;
            if (cam_fin) frame_valid <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        ST_DONE: st_q <= ST_IDLE;
        default: st_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PIC_DMA_CTRL_PINGPONG_EN
  logic wr_bank, rd_bank, bank_q;

  // Completed write becomes the read bank; the camera moves to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      if ((st_q == ST_IDLE) && gnt_vld)
        bank_q <= (gnt_id == REQ_CAM) ? wr_bank : rd_bank;
      else if (xfer_end)
        bank_q <= 1'b0;
      if (cam_fin) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
    end
  end

  assign bank = bank_q;
`else
  assign bank = 1'b0;
`endif

endmodule

// File: tb/tb_pic_dma_ctrl.sv
// Directed self-checking bench for pic_dma_ctrl with an 8-word frame.
module tb_pic_dma_ctrl;
  localparam int FW    = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cam_req = 1'b0, nn_req = 1'b0, abort = 1'b0;
  logic             cam_gnt, nn_gnt, done, aborted, bank;
  logic [1:0]       state;
  logic [CNT_W-1:0] beat;

  int n_chk = 0, n_err = 0;
  logic m_wr = 1'b0, m_rd = 1'b0;

  pic_dma_ctrl #(.FRAME_WORDS(FW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cam_req(cam_req), .nn_req(nn_req), .abort(abort),
    .cam_gnt(cam_gnt), .nn_gnt(nn_gnt), .state(state), .beat(beat),
    .done(done), .aborted(aborted), .bank(bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, state, 2'b00);
    chk({tag, ".gnt"}, {cam_gnt, nn_gnt}, 2'b00);
    chk({tag, ".beat"}, beat, 0);
    chk({tag, ".done"}, {done, aborted}, 2'b00);
    chk({tag, ".bank"}, bank, 1'b0);
  endtask

  function automatic logic exp_bank(input logic is_rd);
`ifdef PIC_DMA_CTRL_PINGPONG_EN
    return is_rd ? m_rd : m_wr;
`else
    return 1'b0;
`endif
  endfunction

  // Caller has the request(s) set while in IDLE; first step lands on the grant.
  task automatic xfer(input logic is_rd, input int abort_at);
    logic eb;
    eb = exp_bank(is_rd);
    for (int i = 0; i < FW; i++) begin
      step();
      chk("xfer.state", state, is_rd ? 2'b10 : 2'b01);
      chk("xfer.gnt", {cam_gnt, nn_gnt}, is_rd ? 2'b01 : 2'b10);
      chk("xfer.beat", beat, i);
      chk("xfer.bank", bank, eb);
      chk("xfer.done", done, 1'b0);
      if (i == abort_at) begin
        abort = 1'b1;
        break;
      end
    end
    step();
    abort = 1'b0;
    chk("done.state", state, 2'b11);
    chk("done.pulse", done, 1'b1);
    chk("done.aborted", aborted, abort_at >= 0);
    chk("done.beat", beat, 0);
    chk("done.gnt", {cam_gnt, nn_gnt}, 2'b00);
    if (!is_rd && abort_at < 0) begin
      m_rd = m_wr;
      m_wr = ~m_wr;
    end
    step();
    chk("idle.state", state, 2'b00);
    chk("idle.pulse", {done, aborted}, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_wr = 1'b0;
    m_rd = 1'b0;
    #3;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // Reset and idle behaviour
    do_reset();
    chk_zero("post_rst");
    abort = 1'b1;
    step(); step();
    chk_zero("idle_abort");
    abort = 1'b0;

    // nn blocked with no frame written
    nn_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("nn_block.gnt", nn_gnt, 1'b0);
      chk("nn_block.state", state, 2'b00);
    end

    // Camera frame while nn still waits; nn follows one cycle after IDLE
    cam_req = 1'b1;
    xfer(1'b0, -1);
    cam_req = 1'b0;
    xfer(1'b1, -1);
    nn_req = 1'b0;
    step();
    chk_zero("quiet");

    // Both held: last grant was nn, so cam, nn, cam
    cam_req = 1'b1;
    nn_req  = 1'b1;
    xfer(1'b0, -1);
    xfer(1'b1, -1);
    xfer(1'b0, -1);
    cam_req = 1'b0;
    nn_req  = 1'b0;
    step();
    chk_zero("alt_end");

    // Fresh start: aborted writes leave banks and frame_valid untouched
    do_reset();
    cam_req = 1'b1;
    xfer(1'b0, 3);
    cam_req = 1'b0;
    chk("abort.bank_model", m_wr, 1'b0);
    cam_req = 1'b1;
    xfer(1'b0, FW - 1);
    cam_req = 1'b0;
    nn_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_block.gnt", nn_gnt, 1'b0);
    end
    nn_req = 1'b0;
    step();

    // Two good camera frames then a read (bank 0, 1, read 1 with ping-pong)
    cam_req = 1'b1;
    xfer(1'b0, -1);
    xfer(1'b0, -1);
    cam_req = 1'b0;
    nn_req = 1'b1;
    xfer(1'b1, -1);
    nn_req = 1'b0;
    step();

    // Async reset in the middle of a read
    nn_req = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rd_mid.beat", beat, 5);
    chk("rd_mid.gnt", nn_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    m_wr = 1'b0;
    m_rd = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_block.gnt", nn_gnt, 1'b0);
      chk("rst_block.state", state, 2'b00);
    end
    nn_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pic_dma_ctrl.md
# pic_dma_ctrl

Sequencer and arbiter for the picture-buffer DMA address generator in the vision datapath. Arbitrates between the camera writer (`cam`) and the NN-accelerator reader (`nn`), each requesting one full-frame transfer. Drives the 2-bit DMA `state` so the generator counts exactly one frame of addresses per grant, then returns it to idle. Sits between the requesters and the picture RAM port.

## Interface
- `FRAME_WORDS`, 1024: words per frame transfer (1..2^CNT_W).
- `CNT_W`, 10: beat-counter width; matches the DMA word-address width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cam_req`  in  1  camera requests one frame write; level, held until `cam_gnt` falls.
- `nn_req`  in  1  accelerator requests one frame read; level, held until `nn_gnt` falls.
- `abort`  in  1  terminates the current transfer early.
- `cam_gnt`  out  1  camera owns the RAM port; high only in state WR.
- `nn_gnt`  out  1  accelerator owns the RAM port; high only in state RD.
- `state`  out  2  DMA command: 00 IDLE, 01 WR, 10 RD, 11 DONE.
- `beat`  out  CNT_W  index of the current word within the transfer.
- `done`  out  1  one-cycle pulse in DONE.
- `aborted`  out  1  valid with `done`: transfer was cut short.
- `bank`  out  1  RAM bank of the current transfer (see Configuration).

## Operation
- All outputs are registered. Reset value of every output is 0; internal `last_gnt` resets to `nn`, so `cam` wins the first tie.
- IDLE:
  - Requests are sampled every cycle.
  - Only `cam_req` -> WR. Only `nn_req` -> RD.
  - Both -> the requester not equal to `last_gnt`. `last_gnt` is updated on every grant.
  - `abort` in IDLE has no effect.
- WR/RD:
  - `beat` starts at 0 and increments by 1 each cycle.
  - `beat == FRAME_WORDS-1` -> DONE next cycle.
  - `abort` -> DONE next cycle with `aborted` = 1. `abort` on the final beat is still reported as aborted.
  - Deasserting a request mid-transfer is ignored.
- DONE: lasts 1 cycle. `done` = 1, grants are 0, `beat` clears to 0, next state is IDLE.
- Counter arithmetic is unsigned CNT_W bits. `beat` never wraps, because the terminal compare fires first.
- An `nn_req` is blocked (not granted) until at least one cam transfer has completed unaborted. The `frame_valid` flag resets to 0.

## Timing
- Request asserted at cycle t while in IDLE -> `state` and grant asserted at t+1.
- Transfer occupies exactly FRAME_WORDS cycles (t+1 .. t+FRAME_WORDS) -> DONE at t+FRAME_WORDS+1 -> IDLE at t+FRAME_WORDS+2.
- Earliest back-to-back grant is at t+FRAME_WORDS+3, so at least 2 non-transfer cycles separate transfers. The downstream address counter clears in both DONE and IDLE.
- Reset asserted mid-transfer: all outputs go to 0 immediately, `frame_valid` and the banks clear, and the transfer is lost.

## Configuration
- `PIC_DMA_CTRL_PINGPONG_EN` defined:
  - Two banks, with registers `wr_bank` (reset 0) and `rd_bank` (reset 0).
  - `bank` = `wr_bank` in WR, `rd_bank` in RD, 0 otherwise.
  - On an unaborted cam DONE: `rd_bank <= wr_bank`, `wr_bank <= ~wr_bank`. An aborted write leaves both banks unchanged.
- Undefined: `bank` is tied to 0 and a single bank is used. The camera overwrites the frame the reader last saw.

## Structure
- Shared package `vision_pkg` holds:
  - state encodings `ST_IDLE`=2'b00, `ST_WR`=2'b01, `ST_RD`=2'b10, `ST_DONE`=2'b11;
  - requester ids `REQ_CAM` / `REQ_NN`.
- One sub-module, `pic_rr_arb2`: 2-way round-robin pick from two requests and `last_gnt`, combinational. The FSM, beat counter and banks stay in the top.

## Test plan
- FRAME_WORDS=8, `cam_req` at cycle 2 -> `state`=01 for cycles 3-10, DONE at 11, `done` pulse, IDLE at 12, `beat` 0..7.
- `nn_req` after reset with no frame written -> no grant for 20 cycles. Then a cam frame completes -> `nn_gnt` follows 1 cycle after IDLE.
- Both requests held continuously -> grants alternate cam, nn, cam, with a 2-cycle gap between transfers.
- `abort` at beat 3 of a WR -> DONE next cycle with `aborted`=1, `beat` cleared, and with PINGPONG `wr_bank` still 0.
- With PINGPONG: two unaborted cam frames, then nn -> first write `bank`=0, second `bank`=1, read `bank`=1.
- `rst_n` pulled low at beat 5 of an RD -> all outputs 0 asynchronously. After release, `nn_req` is blocked again.
